multiplier_control: RTL and testbench

MULTIPLIER_CONTROL -- requirements
Module: multiplier_control

---
 rtl/multiplier_control.sv | 102 ++++++++++
 tb/tb_multiplier_control.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/multiplier_control.sv
// Sequencer for a shift-add (Booth-style final subtract) multiplier datapath.
// Issues one datapath command per cycle: clear/load, ITER add+shift pairs, then holds the result.
module multiplier_control #(
  parameter int unsigned ITER = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Clr_Ld,
  output logic ClearAX,
  output logic Add,
  output logic Sub,
  output logic Shift,
  output logic Busy,
  output logic Done
);

  localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ITER - 1);

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StAdd,
    StShift,
    StHold
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    Clr_Ld  = 1'b0;
    ClearAX = 1'b0;
    Add     = 1'b0;
    Sub     = 1'b0;
    Shift   = 1'b0;
    Busy    = 1'b0;
    Done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Load request wins over Run; gated so reset never leaks a command.
        if (ClearA_LoadB) begin
          Clr_Ld = ~Reset;
        end else if (Run) begin
          state_d = StClr;
        end
      end
      StClr: begin
        ClearAX = 1'b1;
        Busy    = 1'b1;
        cnt_d   = '0;
        state_d = StAdd;
      end
      StAdd: begin
        Busy = 1'b1;
        // Final partial product carries the sign bit's negative weight.
        if (cnt_q == CntLast) begin
          Sub = M;
        end else begin
          Add = M;
        end
        state_d = StShift;
      end
      StShift: begin
        Shift = 1'b1;
        Busy  = 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StHold;
        end else begin
          cnt_d   = cnt_q + CntW'(1);
          state_d = StAdd;
        end
      end
      StHold: begin
        Done = 1'b1;
        if (!Run) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_multiplier_control.sv
// Scoreboard bench for multiplier_control: expected command vectors are queued as stimulus
// is driven and compared mid-cycle against {Clr_Ld, ClearAX, Add, Sub, Shift, Busy, Done}.
module tb_multiplier_control;

  logic Clk = 1'b0;
  logic Reset;
  logic Run;
  logic ClearA_LoadB;
  logic M;
  logic Clr_Ld, ClearAX, Add, Sub, Shift, Busy, Done;
  logic [6:0] outs;

  int n_checks = 0;
  int n_fail   = 0;
  logic [6:0] exp_q[$];

  localparam logic [6:0] VNone  = 7'b0000000;
  localparam logic [6:0] VClrLd = 7'b1000000;
  localparam logic [6:0] VClrAx = 7'b0100010;
  localparam logic [6:0] VShift = 7'b0000110;
  localparam logic [6:0] VDone  = 7'b0000001;

  multiplier_control #(.ITER(8)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .M            (M),
    .Clr_Ld       (Clr_Ld),
    .ClearAX      (ClearAX),
    .Add          (Add),
    .Sub          (Sub),
    .Shift        (Shift),
    .Busy         (Busy),
    .Done         (Done)
  );

  assign outs = {Clr_Ld, ClearAX, Add, Sub, Shift, Busy, Done};

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (Clr_Ld,ClearAX,Add,Sub,Shift,Busy,Done)",
               tag, got, exp);
    end
  endtask

  // Expected vector for cycle k after Run is sampled (k=1 is CLR), given the M driven that cycle.
  function automatic logic [6:0] exp_vec(input int k, input logic mm);
    logic [6:0] v;
    if (k == 1) begin
      v = VClrAx;
    end else if (k <= 17) begin
      if (k % 2 == 0) v = {2'b00, mm && (k < 16), mm && (k == 16), 3'b010};
      else            v = VShift;
    end else begin
      v = VDone;
    end
    return v;
  endfunction

  // Drive one cycle's inputs just after the edge, queue the expectation, compare mid-cycle.
  task automatic step(input logic r, input logic cl, input logic mm, input string tag,
                      input logic [6:0] e);
    Run          = r;
    ClearA_LoadB = cl;
    M            = mm;
    exp_q.push_back(e);
    @(negedge Clk);
    check_eq(tag, outs, exp_q.pop_front());
    @(posedge Clk);
    #1;
  endtask

  task automatic sample_now(input string tag, input logic [6:0] e);
    exp_q.push_back(e);
    check_eq(tag, outs, exp_q.pop_front());
  endtask

  // Full run: start cycle, CLR, 8 add/shift pairs, then n_hold HOLD cycles with Run high.
  task automatic run_seq(input logic m, input bit rnd, input bit cl6, input int n_hold,
                         input string tag);
    logic mm;
    step(1'b1, 1'b0, m, {tag, "_start"}, VNone);
    for (int k = 1; k <= 17; k++) begin
      mm = rnd ? 1'($urandom_range(0, 1)) : m;
      step(1'b1, cl6 && (k == 6), mm, $sformatf("%s_c%0d", tag, k), exp_vec(k, mm));
    end
    for (int h = 0; h < n_hold; h++) begin
      step(1'b1, 1'b0, m, $sformatf("%s_hold%0d", tag, h), VDone);
    end
  endtask

  task automatic drop_run(input string tag);
    step(1'b0, 1'b0, 1'b0, {tag, "_drop"}, VDone);
    step(1'b0, 1'b0, 1'b0, {tag, "_idle"}, VNone);
  endtask

  initial begin
    Reset        = 1'b1;
    Run          = 1'b1;
    ClearA_LoadB = 1'b1;
    M            = 1'b1;
    #2;
    sample_now("reset_state", VNone);
    @(posedge Clk);
    #1;
    Reset = 1'b0;

    // Load requests in IDLE win over Run, then Run starts on the edge after the load drops.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, $sformatf("load%0d", i), VClrLd);
    run_seq(1'b1, 1'b0, 1'b0, 1, "m1");
    drop_run("m1");

    run_seq(1'b0, 1'b0, 1'b0, 1, "m0");
    drop_run("m0");

    run_seq(1'b0, 1'b1, 1'b0, 1, "mrand");
    drop_run("mrand");

    // Run held well into HOLD must not restart; re-raise after IDLE starts a new CLR.
    run_seq(1'b1, 1'b0, 1'b0, 10, "hold");
    drop_run("hold");
    run_seq(1'b1, 1'b0, 1'b0, 0, "rerun");
    drop_run("rerun");

    // Load pulse mid-run is ignored.
    run_seq(1'b1, 1'b0, 1'b1, 1, "ldmid");
    drop_run("ldmid");

    // Run dropped mid-sequence still completes and passes through HOLD once.
    step(1'b1, 1'b0, 1'b1, "early_start", VNone);
    for (int k = 1; k <= 17; k++) begin
      step(1'b0, 1'b0, 1'b1, $sformatf("early_c%0d", k), exp_vec(k, 1'b1));
    end
    step(1'b0, 1'b0, 1'b1, "early_hold", VDone);
    step(1'b0, 1'b0, 1'b1, "early_idle", VNone);

    // Reset during iteration 3's SHIFT (cycle 9) kills all commands immediately.
    step(1'b1, 1'b0, 1'b1, "rst_start", VNone);
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b0, 1'b1, $sformatf("rst_c%0d", k), exp_vec(k, 1'b1));
    end
    sample_now("rst_pre_shift", VShift);
    Reset = 1'b1;
    #1;
    sample_now("rst_async", VNone);
    @(posedge Clk);
    #1;
    sample_now("rst_held", VNone);
    Run   = 1'b0;
    Reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, $sformatf("rst_quiet%0d", i), VNone);
    run_seq(1'b1, 1'b0, 1'b0, 1, "after_rst");
    drop_run("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
